// File: rtl/mrr_downlink_tx_pkg.sv
// mrr_downlink_tx_pkg: shared state encoding, word width and setting helpers
package mrr_downlink_tx_pkg;
    localparam int MRR_TX_WORD_WIDTH = 32;
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_PAYLOAD  = 2'd2,
        ST_RECHARGE = 2'd3
    } tx_state_e;
    function automatic logic [5:0] clamp_bits(input logic [7:0] n);
        return (n > 8'd32) ? 6'd32 : n[5:0];
    endfunction
    function automatic logic [15:0] step_len(input logic [15:0] w);
        return (w == 16'd0) ? 16'd1 : w;
    endfunction
endpackage

// File: rtl/mrr_downlink_tx_if.sv
// mrr_downlink_tx_if: command word stream handshake
interface mrr_downlink_tx_if;
    import mrr_downlink_tx_pkg::*;
    logic [MRR_TX_WORD_WIDTH-1:0] i_tdata;
    logic                         i_tvalid;
    logic                         i_tready;
    modport master (output i_tdata, output i_tvalid, input i_tready);
    modport slave (input i_tdata, input i_tvalid, output i_tready);
endinterface

// File: rtl/mrr_tx_step_timer.sv
// mrr_tx_step_timer: loadable down-counter, tc_o high during the final count
module mrr_tx_step_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             tc_o
);
    logic [WIDTH-1:0] count_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else if (load_i) count_q <= load_val_i;
        else if (count_q != '0) count_q <= count_q - WIDTH'(1);
    end
    assign tc_o = (count_q == WIDTH'(1));
endmodule

// File: rtl/mrr_downlink_tx.sv
// mrr_downlink_tx: preamble + Manchester downlink modulator with recharge gap
// and abort; one command word per packet over a stream handshake.
module mrr_downlink_tx
    import mrr_downlink_tx_pkg::*;
#(
    parameter int          PREAMBLE_LEN     = 8,
    parameter logic [15:0] PREAMBLE_PATTERN = 16'hAA00
) (
    input  logic                clk,
    input  logic                rst_n,
    mrr_downlink_tx_if.slave    cmd,
    input  logic [7:0]          num_payload_bits,
    input  logic [15:0]         wait_step,
    input  logic [14:0]         recharge_len,
    input  logic                tx_disable,
    input  logic [63:0]         cur_time,
    output logic                tx_en,
    output logic                tx_busy,
    output logic [63:0]         o_start_time,
    output logic                o_done,
    output logic                o_aborted
);
    localparam int MSB = MRR_TX_WORD_WIDTH - 1;
    tx_state_e    state_q, state_d;
    logic         tx_en_q, tx_en_d, half_q, half_d, done_q, done_d, aborted_q, aborted_d;
    logic [3:0]   chip_q, chip_d;
    logic [5:0]   bit_q, bit_d, n_q, n_d;
    logic [MSB:0] shift_q, shift_d;
    logic [15:0]  w_q, w_d;
    logic [14:0]  r_q, r_d;
    logic [63:0]  start_q, start_d;
    logic         accept, step_load, step_tc, rc_load, rc_tc;
    assign cmd.i_tready = rst_n & (state_q == ST_IDLE) & ~tx_disable;
    assign accept       = cmd.i_tvalid & cmd.i_tready;
    assign tx_en        = tx_en_q;
    assign tx_busy      = (state_q != ST_IDLE);
    assign o_start_time = start_q;
    assign o_done       = done_q;
    assign o_aborted    = aborted_q;
    mrr_tx_step_timer #(.WIDTH(16)) u_step (
        .clk(clk), .rst_n(rst_n), .load_i(step_load), .load_val_i(w_d), .tc_o(step_tc)
    );
    mrr_tx_step_timer #(.WIDTH(15)) u_recharge (
        .clk(clk), .rst_n(rst_n), .load_i(rc_load),
        .load_val_i((r_q == 15'd0) ? 15'd1 : r_q), .tc_o(rc_tc)
    );
    always_comb begin
        state_d   = state_q;
        tx_en_d   = 1'b0;
        chip_d    = chip_q;
        bit_d     = bit_q;
        half_d    = half_q;
        n_d       = n_q;
        shift_d   = shift_q;
        w_d       = w_q;
        r_d       = r_q;
        start_d   = start_q;
        done_d    = 1'b0;
        aborted_d = aborted_q;
        step_load = 1'b0;
        rc_load   = 1'b0;
        case (state_q)
            ST_IDLE: if (accept) begin
                state_d   = ST_PREAMBLE;
                n_d       = clamp_bits(num_payload_bits);
                // left-align so the first payload bit sits in the MSB
                shift_d   = cmd.i_tdata << (6'(MRR_TX_WORD_WIDTH) - clamp_bits(num_payload_bits));
                w_d       = step_len(wait_step);
                r_d       = recharge_len;
                start_d   = cur_time;
                aborted_d = 1'b0;
                chip_d    = 4'd0;
                step_load = 1'b1;
                tx_en_d   = PREAMBLE_PATTERN[15];
            end
            ST_PREAMBLE, ST_PAYLOAD: if (tx_disable) begin
                state_d   = ST_RECHARGE;
                rc_load   = 1'b1;
                aborted_d = 1'b1;
            end else if (!step_tc) begin
                tx_en_d = tx_en_q;
            end else if (state_q == ST_PREAMBLE && chip_q != 4'(PREAMBLE_LEN - 1)) begin
                chip_d    = chip_q + 4'd1;
                step_load = 1'b1;
                tx_en_d   = PREAMBLE_PATTERN[4'd14 - chip_q];
            end else if (state_q == ST_PREAMBLE && n_q != 6'd0) begin
                state_d   = ST_PAYLOAD;
                bit_d     = n_q - 6'd1;
                half_d    = 1'b0;
                step_load = 1'b1;
                tx_en_d   = shift_q[MSB];
            end else if (state_q == ST_PAYLOAD && !half_q) begin
                half_d    = 1'b1;
                step_load = 1'b1;
                tx_en_d   = ~shift_q[MSB];
            end else if (state_q == ST_PAYLOAD && bit_q != 6'd0) begin
                bit_d     = bit_q - 6'd1;
                half_d    = 1'b0;
                shift_d   = shift_q << 1;
                step_load = 1'b1;
                tx_en_d   = shift_q[MSB-1];
            end else begin
                state_d = ST_RECHARGE;
                rc_load = 1'b1;
            end
            ST_RECHARGE: if (rc_tc) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tx_en_q   <= 1'b0;
            chip_q    <= '0;
            bit_q     <= '0;
            half_q    <= 1'b0;
            n_q       <= '0;
            shift_q   <= '0;
            w_q       <= '0;
            r_q       <= '0;
            start_q   <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_en_q   <= tx_en_d;
            chip_q    <= chip_d;
            bit_q     <= bit_d;
            half_q    <= half_d;
            n_q       <= n_d;
            shift_q   <= shift_d;
            w_q       <= w_d;
            r_q       <= r_d;
            start_q   <= start_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end
endmodule

// File: tb/tb_mrr_downlink_tx.sv
// tb_mrr_downlink_tx: random and directed packets compared cycle by cycle
// against a waveform list built from the preamble/Manchester/recharge rules.
module tb_mrr_downlink_tx;
    localparam logic [15:0] PAT  = 16'hAA00;
    localparam int          PLEN = 8;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  num_payload_bits;
    logic [15:0] wait_step;
    logic [14:0] recharge_len;
    logic        tx_disable;
    logic [63:0] cur_time;
    logic        tx_en, tx_busy, o_done, o_aborted;
    logic [63:0] o_start_time;
    int          n_chk = 0;
    int          n_fail = 0;
    mrr_downlink_tx_if bus ();
    mrr_downlink_tx dut (
        .clk(clk), .rst_n(rst_n), .cmd(bus),
        .num_payload_bits(num_payload_bits), .wait_step(wait_step),
        .recharge_len(recharge_len), .tx_disable(tx_disable), .cur_time(cur_time),
        .tx_en(tx_en), .tx_busy(tx_busy), .o_start_time(o_start_time),
        .o_done(o_done), .o_aborted(o_aborted)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cur_time <= cur_time + 64'd1;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    // Called at a falling edge with the DUT idle (or in its o_done cycle).
    task automatic send(input logic [31:0] w, input int nb, input int ws, input int r,
                        input bit hold, input logic [31:0] nxt, input int abort_at);
        logic q[$];
        int wd, n, rr;
        bit ab;
        logic [63:0] t0;
        wd = (ws == 0) ? 1 : ws;
        n  = (nb > 32) ? 32 : nb;
        rr = (r == 0) ? 1 : r;
        ab = 1'b0;
        for (int k = 0; k < PLEN; k++) repeat (wd) q.push_back(PAT[15-k]);
        for (int i = n - 1; i >= 0; i--) begin
            repeat (wd) q.push_back(w[i]);
            repeat (wd) q.push_back(~w[i]);
        end
        bus.i_tdata = w;
        bus.i_tvalid = 1'b1;
        num_payload_bits = 8'(nb);
        wait_step = 16'(ws);
        recharge_len = 15'(r);
        #1;
        chk("tready_idle", {63'd0, bus.i_tready}, 64'd1);
        t0 = cur_time;
        @(posedge clk);
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin
                wait_step = 16'($urandom);
                num_payload_bits = 8'($urandom);
                recharge_len = 15'($urandom_range(0, 40));
                if (hold) bus.i_tdata = nxt;
                else bus.i_tvalid = 1'b0;
            end
            chk("mod", {60'd0, bus.i_tready, tx_busy, tx_en, o_done}, {60'd0, 1'b0, 1'b1, q[i], 1'b0});
            if (i == abort_at) begin
                tx_disable = 1'b1;
                ab = 1'b1;
                break;
            end
        end
        for (int j = 0; j < rr; j++) begin
            @(negedge clk);
            chk("recharge", {59'd0, bus.i_tready, tx_busy, tx_en, o_done, o_aborted},
                {59'd0, 1'b0, 1'b1, 1'b0, 1'b0, ab});
        end
        @(negedge clk);
        chk("done", {61'd0, tx_busy, o_done, o_aborted}, {61'd0, 1'b0, 1'b1, ab});
        chk("start_time", o_start_time, t0);
    endtask
    initial begin
        logic [31:0] w, nxt;
        bit hold;
        cur_time = {$urandom, $urandom};
        rst_n = 1'b0;
        bus.i_tdata = '0;
        bus.i_tvalid = 1'b1;
        num_payload_bits = 8'd8;
        wait_step = 16'd1;
        recharge_len = 15'd0;
        tx_disable = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tready", {63'd0, bus.i_tready}, 64'd0);
        chk("rst_outs", {60'd0, tx_en, tx_busy, o_done, o_aborted}, 64'd0);
        chk("rst_start", o_start_time, 64'd0);
        bus.i_tvalid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        send(32'hA5000000, 8, 4, 10, 1'b0, 32'd0, -1);
        send($urandom, 0, 1, 0, 1'b0, 32'd0, -1);
        send(32'hFFFFFFFF, 40, 2, 3, 1'b0, 32'd0, -1);
        w = $urandom;
        send(w, 12, 0, 2, 1'b0, 32'd0, -1);
        send(w, 12, 1, 2, 1'b0, 32'd0, -1);
        // abort in the first cycle of payload bit 5
        send($urandom, 16, 2, 3, 1'b0, 32'd0, PLEN * 2 + (16 - 1 - 5) * 4);
        bus.i_tvalid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("disabled_idle", {62'd0, bus.i_tready, tx_busy}, 64'd0);
        end
        bus.i_tvalid = 1'b0;
        tx_disable = 1'b0;
        @(negedge clk);
        w = $urandom;
        nxt = $urandom;
        send(w, 6, 2, 4, 1'b1, nxt, -1);
        w = nxt;
        nxt = $urandom;
        send(w, 5, 1, 0, 1'b1, nxt, -1);
        send(nxt, 7, 3, 2, 1'b0, 32'd0, -1);
        w = $urandom;
        for (int k = 0; k < 10; k++) begin
            nxt = $urandom;
            hold = (k < 9) ? 1'($urandom) : 1'b0;
            send(w, int'($urandom_range(0, 40)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 6)), hold, nxt, -1);
            w = nxt;
        end
        bus.i_tdata = $urandom;
        bus.i_tvalid = 1'b1;
        num_payload_bits = 8'd4;
        wait_step = 16'd3;
        @(posedge clk);
        bus.i_tvalid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", {61'd0, tx_en, tx_busy, o_done}, 64'd0);
        chk("async_rst_tready", {63'd0, bus.i_tready}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(32'h0000C3A5, 16, 1, 2, 1'b0, 32'd0, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
